// File: rtl/bicubic_pkg.sv
// Shared Bicubic package: result-memory geometry defaults and the scan FSM state type.
package bicubic_pkg;

  localparam int unsigned BC_PIX_W      = 8;
  localparam int unsigned BC_ROW_STRIDE = 128;
  localparam int unsigned BC_EXTRA_ROW0 = 100;
  localparam int unsigned BC_N_EXTRA    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAIN  = 2'd1,
    ST_EXTRA = 2'd2,
    ST_DRAIN = 2'd3
  } rc_state_e;

endpackage

// File: rtl/scan_addr_gen.sv
// Address generator for the result scan: raster over the TWxTH target, then the extra rows.
// Holds the i/j counters and the registered read address; flags the last read of each phase.
module scan_addr_gen
  import bicubic_pkg::*;
#(
  parameter int unsigned ROW_STRIDE = BC_ROW_STRIDE,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DIM_W      = 6,
  parameter int unsigned EXTRA_ROW0 = BC_EXTRA_ROW0,
  parameter int unsigned N_EXTRA    = BC_N_EXTRA
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [DIM_W-1:0]  i_tw,
  input  logic [DIM_W-1:0]  i_th,
  output logic              o_main_empty_c,
  output logic              o_extra_empty_c,
  output logic              o_main_last_c,
  output logic              o_last_c,
  output logic [ADDR_W-1:0] o_rd_addr
);

  localparam int unsigned NX_W = $clog2(N_EXTRA + 1);
  localparam int unsigned J_W  = (DIM_W > NX_W) ? DIM_W : NX_W;
  localparam logic [ADDR_W-1:0] EXTRA_BASE = ADDR_W'(EXTRA_ROW0 * ROW_STRIDE);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(ROW_STRIDE);

  logic [DIM_W-1:0]  r_tw, r_th, r_l, r_i;
  logic [J_W-1:0]    r_j;
  logic [ADDR_W-1:0] r_addr, r_row_base;
  logic              r_in_extra, r_extra_empty;

  logic [DIM_W-1:0]  w_max, w_l, w_w;
  logic [J_W-1:0]    w_h;
  logic              w_col_last, w_phase_last;

  // Phase emptiness is judged from the live TW/TH so the FSM can decide at START
  always_comb begin
    w_max           = (i_tw > i_th) ? i_tw : i_th;
    w_l             = w_max - DIM_W'(1);
    o_main_empty_c  = (i_tw == '0) || (i_th == '0);
    o_extra_empty_c = (N_EXTRA == 0) || (w_max <= DIM_W'(1));
    w_w             = r_in_extra ? r_l : r_tw;
    w_h             = r_in_extra ? J_W'(N_EXTRA) : J_W'(r_th);
    w_col_last      = (r_i == w_w - DIM_W'(1));
    w_phase_last    = w_col_last && (r_j == w_h - J_W'(1));
    o_main_last_c   = !r_in_extra && w_phase_last;
    o_last_c        = w_phase_last && (r_in_extra || r_extra_empty);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tw          <= '0;
      r_th          <= '0;
      r_l           <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_addr        <= '0;
      r_row_base    <= '0;
      r_in_extra    <= 1'b0;
      r_extra_empty <= 1'b0;
    end else if (i_load) begin
      r_tw          <= i_tw;
      r_th          <= i_th;
      r_l           <= w_l;
      r_i           <= '0;
      r_j           <= '0;
      r_in_extra    <= o_main_empty_c;
      r_extra_empty <= o_extra_empty_c;
      r_row_base    <= o_main_empty_c ? EXTRA_BASE : '0;
      r_addr        <= o_main_empty_c ? EXTRA_BASE : '0;
    end else if (i_adv) begin
      if (o_main_last_c) begin
        r_in_extra <= 1'b1;
        r_i        <= '0;
        r_j        <= '0;
        r_row_base <= EXTRA_BASE;
        r_addr     <= EXTRA_BASE;
      end else if (w_col_last) begin
        r_i        <= '0;
        r_j        <= r_j + J_W'(1);
        r_row_base <= r_row_base + STRIDE;
        r_addr     <= r_row_base + STRIDE;
      end else begin
        r_i    <= r_i + DIM_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign o_rd_addr = r_addr;

endmodule

// File: rtl/result_checker.sv
// Scans the result memory against two golden copies and counts pixels matching neither.
// Reads are gap-free; each returned pixel is compared one cycle after its read strobe.
module result_checker
  import bicubic_pkg::*;
#(
  parameter int unsigned PIX_W      = BC_PIX_W,
  parameter int unsigned ROW_STRIDE = BC_ROW_STRIDE,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DIM_W      = 6,
  parameter int unsigned EXTRA_ROW0 = BC_EXTRA_ROW0,
  parameter int unsigned N_EXTRA    = BC_N_EXTRA,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DIM_W-1:0]  TW,
  input  logic [DIM_W-1:0]  TH,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [PIX_W-1:0]  RES_DATA,
  input  logic [PIX_W-1:0]  GOLD1_DATA,
  input  logic [PIX_W-1:0]  GOLD2_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic              ERR_FLAG,
  output logic [ADDR_W-1:0] FIRST_ERR_ADDR
);

  rc_state_e         r_state, w_next;
  logic              r_rd_en, r_busy, r_done, r_drain;
  logic              r_cmp_vld, r_err_flag;
  logic [ADDR_W-1:0] r_cmp_addr, r_first_addr;
  logic [CNT_W-1:0]  r_err_cnt;

  logic w_load, w_adv, w_rd_en_nxt, w_done_nxt, w_drain_nxt;
  logic w_main_empty, w_extra_empty, w_main_last, w_last, w_mismatch;

  scan_addr_gen #(
    .ROW_STRIDE (ROW_STRIDE),
    .ADDR_W     (ADDR_W),
    .DIM_W      (DIM_W),
    .EXTRA_ROW0 (EXTRA_ROW0),
    .N_EXTRA    (N_EXTRA)
  ) u_addr (
    .i_clk           (CLK),
    .i_rst           (RST),
    .i_load          (w_load),
    .i_adv           (w_adv),
    .i_tw            (TW),
    .i_th            (TH),
    .o_main_empty_c  (w_main_empty),
    .o_extra_empty_c (w_extra_empty),
    .o_main_last_c   (w_main_last),
    .o_last_c        (w_last),
    .o_rd_addr       (RD_ADDR)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd_en <= w_rd_en_nxt;
      r_busy  <= (w_next != ST_IDLE) || w_done_nxt;
      r_done  <= w_done_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // DRAIN spans two cycles: one for the last data return, one for its compare
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_rd_en_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_drain_nxt = r_drain;
    case (r_state)
      ST_IDLE: begin
        w_drain_nxt = 1'b0;
        if (START) begin
          w_load = 1'b1;
          if (!w_main_empty) begin
            w_next      = ST_MAIN;
            w_rd_en_nxt = 1'b1;
          end else if (!w_extra_empty) begin
            w_next      = ST_EXTRA;
            w_rd_en_nxt = 1'b1;
          end else begin
            w_next = ST_DRAIN;
          end
        end
      end
      ST_MAIN: begin
        w_adv = !w_last;
        if (w_last) begin
          w_next = ST_DRAIN;
        end else begin
          w_rd_en_nxt = 1'b1;
          if (w_main_last) w_next = ST_EXTRA;
        end
      end
      ST_EXTRA: begin
        w_adv = !w_last;
        if (w_last) w_next = ST_DRAIN;
        else        w_rd_en_nxt = 1'b1;
      end
      ST_DRAIN: begin
        if (r_drain) begin
          w_next     = ST_IDLE;
          w_done_nxt = 1'b1;
        end else begin
          w_drain_nxt = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_mismatch = (RES_DATA != GOLD1_DATA) && (RES_DATA != GOLD2_DATA);

  // Compare stage: address travels one cycle behind the read strobe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cmp_vld    <= 1'b0;
      r_cmp_addr   <= '0;
      r_err_cnt    <= '0;
      r_err_flag   <= 1'b0;
      r_first_addr <= '0;
    end else begin
      r_cmp_vld  <= r_rd_en;
      r_cmp_addr <= RD_ADDR;
      if (w_load) begin
        r_err_cnt    <= '0;
        r_err_flag   <= 1'b0;
        r_first_addr <= '0;
      end else if (r_cmp_vld && w_mismatch) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (!r_err_flag) begin
          r_err_flag   <= 1'b1;
          r_first_addr <= r_cmp_addr;
        end
      end
    end
  end

  assign RD_EN          = r_rd_en;
  assign BUSY           = r_busy;
  assign DONE           = r_done;
  assign ERR_CNT        = r_err_cnt;
  assign ERR_FLAG       = r_err_flag;
  assign FIRST_ERR_ADDR = r_first_addr;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: memory model with injectable faults, read monitor,
// and immediate-assertion checks of counts, addresses, timing and reset behaviour.
module tb_result_checker;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DIM_W  = 6;
  localparam int unsigned CNT_W  = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic [DIM_W-1:0]  TW = '0;
  logic [DIM_W-1:0]  TH = '0;
  logic              RD_EN;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [PIX_W-1:0]  RES_DATA = '0;
  logic [PIX_W-1:0]  GOLD1_DATA = '0;
  logic [PIX_W-1:0]  GOLD2_DATA = '0;
  logic              BUSY, DONE, ERR_FLAG;
  logic [CNT_W-1:0]  ERR_CNT;
  logic [ADDR_W-1:0] FIRST_ERR_ADDR;

  int checks = 0;
  int failures = 0;
  int bad_a = -1;
  int bad_b = -1;
  int g2_a = -1;
  int rd_total = 0;
  int rises = 0;
  int q_base = 0;
  logic prev_en = 1'b0;
  int addr_q[$];

  result_checker dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .TW             (TW),
    .TH             (TH),
    .RD_EN          (RD_EN),
    .RD_ADDR        (RD_ADDR),
    .RES_DATA       (RES_DATA),
    .GOLD1_DATA     (GOLD1_DATA),
    .GOLD2_DATA     (GOLD2_DATA),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .ERR_CNT        (ERR_CNT),
    .ERR_FLAG       (ERR_FLAG),
    .FIRST_ERR_ADDR (FIRST_ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gold1(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] gold2(input int a);
    return ~gold1(a);
  endfunction

  function automatic logic [7:0] resv(input int a);
    if (a == bad_a || a == bad_b) return gold1(a) ^ 8'h01;
    if (a == g2_a) return gold2(a);
    return gold1(a);
  endfunction

  // Synchronous memories: data valid the cycle after the strobe
  always @(posedge CLK) begin
    if (RD_EN) begin
      RES_DATA   <= resv(int'(RD_ADDR));
      GOLD1_DATA <= gold1(int'(RD_ADDR));
      GOLD2_DATA <= gold2(int'(RD_ADDR));
    end
  end

  always @(posedge CLK) begin
    if (RD_EN) begin
      rd_total = rd_total + 1;
      addr_q.push_back(int'(RD_ADDR));
      if (!prev_en) rises = rises + 1;
    end
    prev_en = RD_EN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qa(input int idx);
    if (q_base + idx < addr_q.size()) return addr_q[q_base + idx];
    return -1;
  endfunction

  task automatic run_scan(input int tw, input int th, input int exp_n, input string tag,
                          input int glitch_at);
    int base_rd, base_rise, k;
    bit seen;
    @(negedge CLK);
    TW = DIM_W'(tw);
    TH = DIM_W'(th);
    START = 1'b1;
    base_rd = rd_total;
    base_rise = rises;
    q_base = addr_q.size();
    @(posedge CLK);
    #1 START = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      if (k == glitch_at) begin
        START = 1'b1;
        TW = DIM_W'(5);
        TH = DIM_W'(5);
      end
      @(posedge CLK);
      #1 START = 1'b0;
      k = k + 1;
      if (DONE) seen = 1'b1;
    end
    chk({tag, "_done_cycle"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_n + 2));
    chk({tag, "_busy_at_done"}, 32'(BUSY), 32'd1);
    chk({tag, "_reads"}, 32'(rd_total - base_rd), 32'(exp_n));
    chk({tag, "_rd_en_bursts"}, 32'(rises - base_rise), (exp_n > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_idle_after(input string tag);
    @(posedge CLK);
    #1;
    chk({tag, "_done_pulse_end"}, 32'(DONE), 32'd0);
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rd_en", 32'(RD_EN), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("rst_err_flag", 32'(ERR_FLAG), 32'd0);
    chk("rst_first_addr", 32'(FIRST_ERR_ADDR), 32'd0);
    chk("rst_rd_addr", 32'(RD_ADDR), 32'd0);
    RST = 1'b0;

    // 4x3 clean: 12 main + 2 rows of 3 extra
    run_scan(4, 3, 18, "clean4x3", -1);
    chk("clean4x3_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("clean4x3_err_flag", 32'(ERR_FLAG), 32'd0);
    chk("clean4x3_a0", 32'(qa(0)), 32'd0);
    chk("clean4x3_a4", 32'(qa(4)), 32'd128);
    chk("clean4x3_a11", 32'(qa(11)), 32'd259);
    chk("clean4x3_a12", 32'(qa(12)), 32'd12800);
    chk("clean4x3_a14", 32'(qa(14)), 32'd12802);
    chk("clean4x3_a15", 32'(qa(15)), 32'd12928);
    chk("clean4x3_a17", 32'(qa(17)), 32'd12930);
    chk_idle_after("clean4x3");

    bad_a = 130;
    g2_a = 257;
    run_scan(4, 3, 18, "err4x3", -1);
    chk("err4x3_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("err4x3_err_flag", 32'(ERR_FLAG), 32'd1);
    chk("err4x3_first", 32'(FIRST_ERR_ADDR), 32'd130);
    repeat (3) @(posedge CLK);
    #1;
    chk("err4x3_hold_cnt", 32'(ERR_CNT), 32'd1);
    chk("err4x3_hold_first", 32'(FIRST_ERR_ADDR), 32'd130);
    bad_a = -1;
    g2_a = -1;

    run_scan(1, 1, 1, "one1x1", -1);
    chk("one1x1_a0", 32'(qa(0)), 32'd0);
    chk("one1x1_err_cleared", 32'(ERR_CNT), 32'd0);
    chk("one1x1_flag_cleared", 32'(ERR_FLAG), 32'd0);

    run_scan(0, 0, 0, "empty0x0", -1);
    chk_idle_after("empty0x0");

    // TW=0 but L=4: only the extra rows are read
    run_scan(0, 5, 8, "extra_only", -1);
    chk("extra_only_a0", 32'(qa(0)), 32'd12800);
    chk("extra_only_a4", 32'(qa(4)), 32'd12928);
    chk("extra_only_a7", 32'(qa(7)), 32'd12931);

    bad_a = 5;
    bad_b = 12931;
    run_scan(6, 6, 46, "big6x6", -1);
    chk("big6x6_a35", 32'(qa(35)), 32'd645);
    chk("big6x6_a36", 32'(qa(36)), 32'd12800);
    chk("big6x6_a40", 32'(qa(40)), 32'd12804);
    chk("big6x6_a41", 32'(qa(41)), 32'd12928);
    chk("big6x6_a45", 32'(qa(45)), 32'd12932);
    chk("big6x6_err_cnt", 32'(ERR_CNT), 32'd2);
    chk("big6x6_first", 32'(FIRST_ERR_ADDR), 32'd5);
    bad_a = -1;
    bad_b = -1;

    // Abort mid-MAIN after a mismatch has already been counted
    bad_a = 1;
    @(negedge CLK);
    TW = DIM_W'(4);
    TH = DIM_W'(3);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_pre_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("abort_pre_first", 32'(FIRST_ERR_ADDR), 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_rd_en", 32'(RD_EN), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("abort_err_flag", 32'(ERR_FLAG), 32'd0);
    chk("abort_first", 32'(FIRST_ERR_ADDR), 32'd0);
    chk("abort_rd_addr", 32'(RD_ADDR), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_post_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("abort_post_rd_en", 32'(RD_EN), 32'd0);
    bad_a = 129;

    // Restart after abort, with a stray START while busy
    run_scan(2, 2, 6, "restart2x2", 2);
    chk("restart2x2_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("restart2x2_first", 32'(FIRST_ERR_ADDR), 32'd129);
    chk("restart2x2_a3", 32'(qa(3)), 32'd129);
    chk("restart2x2_a4", 32'(qa(4)), 32'd12800);
    chk_idle_after("restart2x2");
    bad_a = -1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
